// File: rtl/seq_guess_engine.sv
// seq_guess_engine: two-player sequence-guessing game for the button/LED board.
// Player A enters a secret symbol sequence; player B gets TRIES evaluated
// guesses to reproduce it. Game state only advances on a divided sample tick.
//
// Ports:
//   CLK, reset (async, active-high)
//   btn[NBTN], enter       : raw level buttons, asynchronous to the tick
//   phase                  : 0=SET_A 1=GUESS 2=WON 3=LOST
//   win, lose              : game result LEDs
//   equal/bigger/smaller   : last evaluated guess length vs secret length
//   last_btn               : one-hot of last stored symbol
//   len_a, len_b, turn     : secret length, current guess length, failed guesses
//   hits                   : correct-position count of the last evaluated guess
//
// Optional feature macro: GUESS_HINT_EN (builds the per-position hit counter;
// without it `hits` is tied to 0).
module seq_guess_engine #(
  parameter int NBTN   = 4,
  parameter int MAXLEN = 7,
  parameter int MINLEN = 4,
  parameter int TRIES  = 3,
  parameter int DIV    = 100000,
  localparam int LW    = $clog2(MAXLEN + 1),
  localparam int TW    = $clog2(TRIES + 1)
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [NBTN-1:0] btn,
  input  logic            enter,
  output logic [1:0]      phase,
  output logic            win,
  output logic            lose,
  output logic            equal,
  output logic            bigger,
  output logic            smaller,
  output logic [NBTN-1:0] last_btn,
  output logic [LW-1:0]   len_a,
  output logic [LW-1:0]   len_b,
  output logic [TW-1:0]   turn,
  output logic [LW-1:0]   hits
);
  localparam int SW = $clog2(NBTN);
  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {SET_A = 2'd0, GUESS = 2'd1, WON = 2'd2, LOST = 2'd3} state_t;
  state_t state;

  logic [CW-1:0]   div_cnt;
  logic            tick;
  // Two-flop synchronisers: the buttons are asynchronous to CLK. They add two
  // CLK cycles of delay, which is negligible against the tick period.
  logic [NBTN-1:0] btn_m, btn_s, btn_prev;
  logic            ent_m, ent_s, ent_prev;
  logic [NBTN-1:0] new_btn;
  logic            new_ent;
  logic            sym_vld;
  logic [SW-1:0]   sym;
  logic            a_wr, b_wr;
  logic [LW-1:0]   la_nxt, lb_nxt;
  logic            match_all, match;
  logic [SW-1:0]   bsym;
  logic [SW-1:0]   mem_a [MAXLEN];
  logic [SW-1:0]   mem_b [MAXLEN];
`ifdef GUESS_HINT_EN
  logic [LW-1:0]   hit_cnt;
`endif

  assign tick    = (div_cnt == CW'(DIV - 1));
  assign new_btn = btn_s & ~btn_prev;
  assign new_ent = ent_s & ~ent_prev;
  assign phase   = state;

  // Lowest-index new press wins; simultaneous higher presses are dropped.
  always_comb begin
    sym_vld = 1'b0;
    sym     = '0;
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (new_btn[i]) begin
        sym_vld = 1'b1;
        sym     = SW'(i);
      end
    end
  end

  // len_a < MAXLEN always holds in SET_A because reaching MAXLEN leaves it.
  assign a_wr   = (state == SET_A) && sym_vld;
  assign b_wr   = (state == GUESS) && sym_vld && (len_b < LW'(MAXLEN));
  assign la_nxt = len_a + LW'(a_wr);
  assign lb_nxt = len_b + LW'(b_wr);

  // Evaluation sees the guess including a symbol appended on this same tick.
  always_comb begin
    match_all = 1'b1;
    bsym      = '0;
`ifdef GUESS_HINT_EN
    hit_cnt   = '0;
`endif
    for (int i = 0; i < MAXLEN; i++) begin
      bsym = (b_wr && (len_b == LW'(i))) ? sym : mem_b[i];
      if ((i < int'(len_a)) && (bsym != mem_a[i]))
        match_all = 1'b0;
`ifdef GUESS_HINT_EN
      if ((i < int'(len_a)) && (i < int'(lb_nxt)) && (bsym == mem_a[i]))
        hit_cnt = hit_cnt + LW'(1);
`endif
    end
  end
  assign match = (lb_nxt == len_a) && match_all;

  // Symbol storage carries no reset; only the lengths qualify its contents.
  always_ff @(posedge CLK) begin
    if (tick && a_wr) mem_a[len_a] <= sym;
    if (tick && b_wr) mem_b[len_b] <= sym;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= SET_A;
      div_cnt  <= '0;
      btn_m    <= '0;
      btn_s    <= '0;
      btn_prev <= '0;
      ent_m    <= 1'b0;
      ent_s    <= 1'b0;
      ent_prev <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      equal    <= 1'b0;
      bigger   <= 1'b0;
      smaller  <= 1'b0;
      last_btn <= '0;
      len_a    <= '0;
      len_b    <= '0;
      turn     <= '0;
`ifdef GUESS_HINT_EN
      hits     <= '0;
`endif
    end else begin
      btn_m   <= btn;
      btn_s   <= btn_m;
      ent_m   <= enter;
      ent_s   <= ent_m;
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
      if (tick) begin
        btn_prev <= btn_s;
        ent_prev <= ent_s;
        case (state)
          SET_A: begin
            if (a_wr) last_btn <= NBTN'(1) << sym;
            if (la_nxt == LW'(MAXLEN)) begin
              len_a <= la_nxt;
              state <= GUESS;
            end else if (new_ent) begin
              if (la_nxt >= LW'(MINLEN)) begin
                len_a <= la_nxt;
                state <= GUESS;
              end else begin
                len_a <= '0;            // too short: secret discarded
              end
            end else begin
              len_a <= la_nxt;
            end
          end
          GUESS: begin
            if (b_wr) last_btn <= NBTN'(1) << sym;
            if (new_ent) begin
              if (lb_nxt < LW'(MINLEN)) begin
                len_b <= '0;            // short guess: no turn consumed
              end else begin
                smaller <= (lb_nxt > len_a);
                equal   <= (lb_nxt == len_a);
                bigger  <= (lb_nxt < len_a);
`ifdef GUESS_HINT_EN
                hits    <= hit_cnt;
`endif
                if (match) begin
                  len_b <= lb_nxt;
                  win   <= 1'b1;
                  state <= WON;
                end else begin
                  len_b <= '0;
                  turn  <= turn + TW'(1);
                  if (turn == TW'(TRIES - 1)) begin
                    lose  <= 1'b1;
                    state <= LOST;
                  end
                end
              end
            end else begin
              len_b <= lb_nxt;
            end
          end
          default: ;                    // WON/LOST hold until reset
        endcase
      end
    end
  end

`ifndef GUESS_HINT_EN
  assign hits = '0;
`endif

endmodule

// File: tb/tb_seq_guess_engine.sv
// Scoreboard bench for seq_guess_engine with a queue-based reference model.
module tb_seq_guess_engine;
  localparam int BN = 4;
  localparam int ML = 7;
  localparam int MN = 4;
  localparam int TR = 3;
  localparam int DV = 4;
  localparam int LW = $clog2(ML + 1);
  localparam int TW = $clog2(TR + 1);

  typedef struct packed {
    logic [1:0]    ph;
    logic          win, lose, eq, big, sml;
    logic [BN-1:0] last;
    logic [LW-1:0] la, lb;
    logic [TW-1:0] turn;
    logic [LW-1:0] hits;
  } snap_t;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [BN-1:0] btn = '0;
  logic          enter = 1'b0;
  logic [1:0]    phase;
  logic          win, lose, equal, bigger, smaller;
  logic [BN-1:0] last_btn;
  logic [LW-1:0] len_a, len_b, hits;
  logic [TW-1:0] turn;

  seq_guess_engine #(.NBTN(BN), .MAXLEN(ML), .MINLEN(MN), .TRIES(TR), .DIV(DV)) dut (
    .CLK(CLK), .reset(reset), .btn(btn), .enter(enter), .phase(phase),
    .win(win), .lose(lose), .equal(equal), .bigger(bigger), .smaller(smaller),
    .last_btn(last_btn), .len_a(len_a), .len_b(len_b), .turn(turn), .hits(hits)
  );

  always #5 CLK = ~CLK;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t sb[$];
  event  tick_done;
  int    ecnt = 0;

  // Reference model: game state as plain queues and integers.
  int    secret[$];
  int    guess[$];
  int    m_ph, m_turn, m_hits, m_last;
  bit    m_win, m_lose, m_eq, m_big, m_sml;
  bit [BN-1:0] m_prev_b;
  bit    m_prev_e;

  task automatic model_reset();
    secret.delete(); guess.delete();
    m_ph = 0; m_turn = 0; m_hits = 0; m_last = 0;
    m_win = 0; m_lose = 0; m_eq = 0; m_big = 0; m_sml = 0;
    m_prev_b = '0; m_prev_e = 0;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.ph = 2'(m_ph); s.win = m_win; s.lose = m_lose;
    s.eq = m_eq; s.big = m_big; s.sml = m_sml;
    s.last = BN'(m_last); s.la = LW'(secret.size()); s.lb = LW'(guess.size());
    s.turn = TW'(m_turn);
`ifdef GUESS_HINT_EN
    s.hits = LW'(m_hits);
`else
    s.hits = '0;
`endif
    return s;
  endfunction

  task automatic model_step(input bit [BN-1:0] b, input bit e);
    bit [BN-1:0] np;
    bit          ne;
    int          s, h, n;
    np = b & ~m_prev_b;
    ne = e && !m_prev_e;
    m_prev_b = b; m_prev_e = e;
    s = -1;
    for (int i = 0; i < BN; i++) if (np[i]) begin s = i; break; end
    if (m_ph == 0) begin
      if (s >= 0) begin secret.push_back(s); m_last = 1 << s; end
      if (secret.size() == ML) m_ph = 1;
      else if (ne) begin
        if (secret.size() >= MN) m_ph = 1; else secret.delete();
      end
    end else if (m_ph == 1) begin
      if (s >= 0 && guess.size() < ML) begin guess.push_back(s); m_last = 1 << s; end
      if (ne) begin
        if (guess.size() < MN) guess.delete();
        else begin
          m_sml = guess.size() > secret.size();
          m_eq  = guess.size() == secret.size();
          m_big = guess.size() < secret.size();
          n = (guess.size() < secret.size()) ? guess.size() : secret.size();
          h = 0;
          for (int i = 0; i < n; i++) if (guess[i] == secret[i]) h++;
          m_hits = h;
          if (m_eq && h == secret.size()) begin m_ph = 2; m_win = 1; end
          else begin
            guess.delete();
            m_turn++;
            if (m_turn == TR) begin m_ph = 3; m_lose = 1; end
          end
        end
      end
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.ph = phase; s.win = win; s.lose = lose; s.eq = equal; s.big = bigger;
    s.sml = smaller; s.last = last_btn; s.la = len_a; s.lb = len_b;
    s.turn = turn; s.hits = hits;
    return s;
  endfunction

  task automatic check_one(input string tag);
    snap_t x, a;
    if (sb.size() == 0) return;
    x = sb.pop_front();
    a = dut_snap();
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s @%0t: got ph=%0d win=%0b lose=%0b eq=%0b big=%0b sml=%0b last=%b la=%0d lb=%0d turn=%0d hits=%0d | want ph=%0d win=%0b lose=%0b eq=%0b big=%0b sml=%0b last=%b la=%0d lb=%0d turn=%0d hits=%0d",
               tag, $time, a.ph, a.win, a.lose, a.eq, a.big, a.sml, a.last, a.la, a.lb, a.turn, a.hits,
               x.ph, x.win, x.lose, x.eq, x.big, x.sml, x.last, x.la, x.lb, x.turn, x.hits);
    end
  endtask

  // Monitor: outputs update on every DV-th CLK edge after reset release.
  initial forever begin
    @(posedge CLK);
    if (reset) ecnt = 0;
    else begin
      ecnt++;
      if (ecnt % DV == 0) begin
        #1;
        check_one("tick");
        ->tick_done;
      end
    end
  end

  // Asynchronous reset, asserted away from any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1; btn = '0; enter = 1'b0;
    model_reset();
    sb.push_back(model_snap());
    #1;
    check_one("reset");
    repeat (2) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic step(input logic [BN-1:0] b, input logic e);
    @(negedge CLK);
    btn = b; enter = e;
    model_step(b, e);
    sb.push_back(model_snap());
    @(tick_done);
  endtask

  task automatic press(input int s);
    step(BN'(1) << s, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic ent();
    step('0, 1'b1);
    step('0, 1'b0);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Win on first guess.
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    ent();
    for (int i = 0; i < 4; i++) press(i);
    ent();
    press(2);
    // Short secret discarded, then auto-advance at MAXLEN; guess overflow ignored.
    do_reset();
    for (int i = 0; i < 3; i++) press(i);
    ent();
    for (int i = 0; i < 7; i++) press(i % BN);
    for (int i = 0; i < 8; i++) press((i + 1) % BN);
    ent();
    // Three wrong guesses -> lost; further presses ignored.
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    ent();
    for (int g = 0; g < 3; g++) begin
      for (int i = 3; i >= 0; i--) press(i);
      ent();
    end
    press(1);
    press(2);
    // Length comparisons and hits; final symbol+enter on the same tick wins.
    do_reset();
    for (int i = 0; i < 5; i++) press(1);
    ent();
    for (int i = 0; i < 4; i++) press(1);
    ent();
    for (int i = 0; i < 6; i++) press(1);
    ent();
    step('0, 1'b1);  // enter with empty guess: no turn consumed
    step('0, 1'b0);
    for (int i = 0; i < 4; i++) press(1);
    step(BN'(2), 1'b1);
    step('0, 1'b0);
    // Simultaneous presses and a held button.
    do_reset();
    step(BN'(6), 1'b0);
    step('0, 1'b0);
    for (int i = 0; i < 5; i++) step(BN'(1), 1'b0);
    step('0, 1'b0);
    // Reset mid-GUESS with two turns used.
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    ent();
    for (int g = 0; g < 2; g++) begin
      for (int i = 3; i >= 0; i--) press(i);
      ent();
    end
    press(1);
    do_reset();
    step('0, 1'b0);
    // Random games.
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int k = 0; k < 60; k++) begin
        logic [BN-1:0] rb;
        logic          re;
        rb = ($urandom_range(0, 2) == 0) ? '0 : BN'($urandom_range(0, (1 << BN) - 1));
        re = ($urandom_range(0, 7) == 0);
        step(rb, re);
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_guess_engine.md
# seq_guess_engine

Parametrised two-player sequence-guessing engine for the FPGA button/LED board. Player A enters a secret sequence of button symbols, player B gets a fixed number of tries to reproduce it, and the block drives win/lose and length-comparison LEDs. Button inputs are sampled at a divided tick with per-button edge detection; all state is held in one FSM plus two sequence memories.

## Interface
- `NBTN`, 4: number of symbol buttons (≥2)
- `MAXLEN`, 7: maximum sequence length; auto-advance when the secret reaches it
- `MINLEN`, 4: minimum length for an accepted enter (1..MAXLEN)
- `TRIES`, 3: number of evaluated guesses before loss (≥1)
- `DIV`, 100000: CLK cycles per sample tick (≥2)
- Width `LW` = clog2(MAXLEN+1); width `TW` = clog2(TRIES+1)

Ports:
- `CLK` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `btn` in NBTN: symbol buttons, level, active-high, asynchronous to tick
- `enter` in 1: enter button, level, active-high
- `phase` out 2: 0=SET_A, 1=GUESS, 2=WON, 3=LOST
- `win`, `lose` out 1: game result LEDs
- `equal`, `bigger`, `smaller` out 1: last evaluated guess length vs secret length
- `last_btn` out NBTN: one-hot of last accepted symbol
- `len_a` out LW: secret length so far
- `len_b` out LW: current guess length
- `turn` out TW: evaluated failed guesses
- `hits` out LW: correct-position count of last evaluated guess (see Configuration)

## Operation
- Divider counts 0..DIV-1; `tick` asserts for one CLK when count == DIV-1. All game state changes only on tick.
- On tick, sample `btn`/`enter`; a press = sampled 1 and previous sample 0. Previous-sample register resets to 0, so a button held through reset counts as one press at the first tick.
- At most one symbol accepted per tick: lowest-index new press wins; other simultaneous new presses are discarded (not deferred). An accepted symbol sets `last_btn` to its one-hot.
- Symbol then enter on the same tick: symbol is appended first, then enter is evaluated with the new length.
- SET_A: press with len_a<MAXLEN stores symbol at index len_a, len_a++. If len_a reaches MAXLEN -> GUESS. Enter: len_a≥MINLEN -> GUESS; else len_a=0 (secret discarded).
- GUESS: press with len_b<MAXLEN stores at index len_b, len_b++; at MAXLEN further presses ignored (no auto-evaluate). Enter with len_b<MINLEN: len_b=0, no turn consumed, compare LEDs unchanged.
- Enter with len_b≥MINLEN evaluates: match = (len_b==len_a) and all stored symbols equal. Compare LEDs one-hot: `smaller` if len_b>len_a, `equal` if equal, `bigger` if len_b<len_a. Match -> WON, win=1. Else turn++, len_b=0; if turn reaches TRIES -> LOST, lose=1.
- WON/LOST absorbing; all inputs ignored until reset. Dividers keep running.

## Timing
- Reset (async): every output 0, phase=SET_A, divider=0, memories need not clear (only lengths).
- Outputs are registered; they change on the CLK edge where tick=1 and are stable for the following DIV cycles.
- First tick after reset release occurs at CLK edge DIV. Press latency: 1 tick after the first tick where the level is sampled high.
- Reset mid-game: immediate return to SET_A, turn=0, all LEDs off.
- `turn` never exceeds TRIES; no wrap.

## Configuration
- `GUESS_HINT_EN` defined: on each evaluated enter, `hits` = count of indices i < min(len_a,len_b) with equal symbols; held until next evaluation or reset.
- Not defined: `hits` constant 0, per-position counter not built; all other behaviour identical.

## Test plan
- DIV=4 defaults: press 1,2,3,4, enter -> phase=1, len_a=4; guess 1,2,3,4, enter -> win=1, phase=2, equal=1.
- Secret 1,2,3 + enter -> len_a=0, phase=0; then seven presses -> phase=1 automatically, len_a=7.
- Secret 1,2,3,4; three guesses 4,3,2,1 -> turn 1,2, then lose=1, phase=3; further presses leave len_b=0.
- Secret 1,1,1,1,1; guess 1,1,1,1 enter -> bigger=1, turn=1; guess of 6 symbols -> smaller=1; with GUESS_HINT_EN hits=4 then 5.
- btn=0b0110 new on one tick -> only symbol 1 stored, last_btn=0b0010; held button over 5 ticks -> one symbol.
- Assert reset mid-GUESS with turn=2 -> all outputs 0, phase=0 within same cycle (async).
